cpu_mem_arbiter: RTL

//  Shares one external memory port between the CPU I-Port (instruction fetch) and D-Port (load/store).

---
 rtl/cpu_mem_arbiter_pkg.sv | 39 +++
 rtl/cpu_mem_arbiter_req_slot.sv | 58 +++++
 rtl/cpu_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : cpu_mem_arbiter_pkg                                          |
// | Description : Shared widths, FSM state encoding, port identifiers and the  |
// |               captured-request record used by the CPU memory arbiter.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_mem_arbiter_pkg;

  localparam int c_ADDR_WIDTH = 32;
  localparam int c_DATA_WIDTH = 32;
  localparam int c_BEN_WIDTH  = 4;

  // Arbiter FSM encoding (2 bits)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  // Requesting port identifiers
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // One captured memory request
  typedef struct packed {
    logic [c_ADDR_WIDTH-1:0] addr;
    logic                    rnw;
    logic [c_BEN_WIDTH-1:0]  ben;
    logic [c_DATA_WIDTH-1:0] data;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/cpu_mem_arbiter_req_slot.sv
// +----------------------------------------------------------------------------+
// | Module      : arb_req_slot                                                 |
// | Description : One-deep pending slot for a single requesting port. Latches  |
// |               the request fields on a request pulse, releases at grant and |
// |               flags a pulse that arrives while the port is still occupied. |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               i_req, i_fields - request pulse and its fields               |
// |               i_busy          - this port owns the transaction in flight   |
// |               i_grant         - slot wins arbitration this cycle           |
// |               o_pending       - slot holds an un-granted request           |
// |               o_fields        - captured fields                            |
// |               o_proto_err     - request pulse dropped (1-cycle)            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_req_slot
  import cpu_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req,
  input  mem_req_t i_fields,
  input  logic     i_busy,
  input  logic     i_grant,
  output logic     o_pending,
  output mem_req_t o_fields,
  output logic     o_proto_err
);

  logic     r_pending;
  mem_req_t r_fields;
  logic     w_accept;

  // The port is occupied from capture until its response cycle; a pulse
  // during that window is dropped. A grant always finds the slot full, so
  // capture and release can never coincide.
  assign w_accept    = i_req & ~r_pending & ~i_busy;
  assign o_proto_err = i_req & (r_pending | i_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_fields  <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_fields  <= i_fields;
    end else if (i_grant) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_fields  = r_fields;

endmodule

`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : cpu_mem_arbiter                                              |
// | Description : Shares one external memory port between the CPU instruction |
// |               fetch port (I) and load/store port (D). One transaction in   |
// |               flight; D has priority with a starvation guard for I and a   |
// |               response watchdog.                                           |
// | Ports       : clk, rst                  - clock, sync active-high reset    |
// |               i_IAddr/i_IRdC            - fetch request                    |
// |               o_IData/o_IRdy/o_IErr     - fetch response                   |
// |               i_DAddr/i_DCmd/i_DRnW/i_DBen/i_DData - data request          |
// |               o_DData/o_DRdy/o_DErr     - data response                    |
// |               o_MAddr/o_MCmd/o_MRnW/o_MBen/o_MData - bus command           |
// |               i_MData/i_MRdy/i_MErr     - bus response                     |
// |               o_ProtoErr                - sticky request-overrun flag      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [c_ADDR_WIDTH-1:0] i_IAddr,
  input  logic                    i_IRdC,
  output logic [c_DATA_WIDTH-1:0] o_IData,
  output logic                    o_IRdy,
  output logic                    o_IErr,
  input  logic [c_ADDR_WIDTH-1:0] i_DAddr,
  input  logic                    i_DCmd,
  input  logic                    i_DRnW,
  input  logic [c_BEN_WIDTH-1:0]  i_DBen,
  input  logic [c_DATA_WIDTH-1:0] i_DData,
  output logic [c_DATA_WIDTH-1:0] o_DData,
  output logic                    o_DRdy,
  output logic                    o_DErr,
  output logic [c_ADDR_WIDTH-1:0] o_MAddr,
  output logic                    o_MCmd,
  output logic                    o_MRnW,
  output logic [c_BEN_WIDTH-1:0]  o_MBen,
  output logic [c_DATA_WIDTH-1:0] o_MData,
  input  logic [c_DATA_WIDTH-1:0] i_MData,
  input  logic                    i_MRdy,
  input  logic                    i_MErr,
  output logic                    o_ProtoErr
);

  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int c_WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  // The watchdog counts WAIT cycles from 0; the TIMEOUT-th silent cycle ends the wait.
  localparam logic [c_WD_W-1:0]     c_WD_LAST    = c_WD_W'(TIMEOUT - 1);

  arb_state_t              r_state, w_next_state;
  arb_port_t               r_owner;
  logic                    r_err;
  logic [c_STARVE_W-1:0]   r_starve;
  logic [c_WD_W-1:0]       r_wd;
  mem_req_t                r_mreq;
  logic [c_DATA_WIDTH-1:0] r_idata, r_ddata;
  logic                    r_proto;

  logic     w_i_pend, w_d_pend, w_i_busy, w_d_busy;
  logic     w_i_grant, w_d_grant, w_i_perr, w_d_perr;
  logic     w_grant_any, w_win_d, w_in_flight;
  mem_req_t w_i_in, w_d_in, w_i_slot, w_d_slot;

  // Fetches are always full-word reads.
  assign w_i_in = '{addr: i_IAddr, rnw: 1'b1, ben: '1, data: '0};
  assign w_d_in = '{addr: i_DAddr, rnw: i_DRnW, ben: i_DBen, data: i_DData};

  // Owner port is busy from ISSUE through WAIT; it may re-request from RESP on.
  assign w_in_flight = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_i_busy    = w_in_flight && (r_owner == PORT_I);
  assign w_d_busy    = w_in_flight && (r_owner == PORT_D);

  arb_req_slot u_slot_i (
    .clk(clk), .rst(rst), .i_req(i_IRdC), .i_fields(w_i_in), .i_busy(w_i_busy),
    .i_grant(w_i_grant), .o_pending(w_i_pend), .o_fields(w_i_slot), .o_proto_err(w_i_perr)
  );

  arb_req_slot u_slot_d (
    .clk(clk), .rst(rst), .i_req(i_DCmd), .i_fields(w_d_in), .i_busy(w_d_busy),
    .i_grant(w_d_grant), .o_pending(w_d_pend), .o_fields(w_d_slot), .o_proto_err(w_d_perr)
  );

  always_comb begin
    w_next_state = r_state;
    w_grant_any  = 1'b0;
    w_win_d      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_pend || w_d_pend) begin
          w_grant_any  = 1'b1;
          // D wins unless I has been passed over STARVE_LIMIT times in a row.
          w_win_d      = w_d_pend && !(w_i_pend && (r_starve == c_STARVE_MAX));
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (i_MRdy || i_MErr || (r_wd == c_WD_LAST)) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_i_grant = w_grant_any && !w_win_d;
  assign w_d_grant = w_grant_any && w_win_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= PORT_I;
      r_err    <= 1'b0;
      r_starve <= '0;
      r_wd     <= '0;
      r_mreq   <= '0;
      r_idata  <= '0;
      r_ddata  <= '0;
      r_proto  <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_i_perr || w_d_perr) begin
        r_proto <= 1'b1;
      end

      if (w_grant_any) begin
        r_owner <= w_win_d ? PORT_D : PORT_I;
        r_mreq  <= w_win_d ? w_d_slot : w_i_slot;
      end

      if (w_d_grant && w_i_pend) begin
        r_starve <= r_starve + 1'b1;
      end else if (w_i_grant || !w_i_pend) begin
        r_starve <= '0;
      end

      if (r_state == S_ISSUE) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end

      if (r_state == S_WAIT) begin
        if (i_MRdy || i_MErr) begin
          r_err <= i_MErr;  // error wins over a simultaneous ready
          if (r_owner == PORT_D) begin
            r_ddata <= i_MData;
          end else begin
            r_idata <= i_MData;
          end
        end else if (r_wd == c_WD_LAST) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_MCmd     = (r_state == S_ISSUE);
  assign o_MAddr    = r_mreq.addr;
  assign o_MRnW     = r_mreq.rnw;
  assign o_MBen     = r_mreq.ben;
  assign o_MData    = r_mreq.data;
  assign o_IRdy     = (r_state == S_RESP) && (r_owner == PORT_I) && !r_err;
  assign o_IErr     = (r_state == S_RESP) && (r_owner == PORT_I) &&  r_err;
  assign o_DRdy     = (r_state == S_RESP) && (r_owner == PORT_D) && !r_err;
  assign o_DErr     = (r_state == S_RESP) && (r_owner == PORT_D) &&  r_err;
  assign o_IData    = r_idata;
  assign o_DData    = r_ddata;
  assign o_ProtoErr = r_proto;

endmodule

`default_nettype wire
